// File: rtl/wm_extract.sv
// Watermark extraction engine. Walks a WM_DIM x WM_DIM window of the image RAM and
// recovers each 2-bit watermark symbol from the pixel LSBs. The symbol is descrambled
// with the key-seeded LFSR keystream and written to the watermark RAM at the
// window-relative coordinate. Each pixel takes three cycles: read, wait, write.
module wm_extract #(
  parameter int unsigned WM_DIM = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] key_i,
  input  logic [7:0] a1_i,
  input  logic [7:0] a2_i,
  input  logic [7:0] im_data_in_i,
  output logic [7:0] row_im_addr_o,
  output logic [7:0] col_im_addr_o,
  output logic       im_rd_wrn_o,
  output logic [7:0] row_wm_addr_o,
  output logic [7:0] col_wm_addr_o,
  output logic [1:0] wm_data_o,
  output logic       wm_rd_wrn_o,
  output logic       ready_o,
  output logic       busy_o
);

  localparam logic [7:0] LastIdx = 8'(WM_DIM - 1);

  typedef enum logic [1:0] {StIdle, StRd, StWait, StWr} state_e;

  state_e     state_q, state_d;
  logic [7:0] a1_q, a1_d;
  logic [7:0] a2_q, a2_d;
  logic [7:0] r_q, r_d;
  logic [7:0] c_q, c_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] row_im_q, row_im_d;
  logic [7:0] col_im_q, col_im_d;
  logic [7:0] row_wm_q, row_wm_d;
  logic [7:0] col_wm_q, col_wm_d;
  logic [1:0] wm_data_q, wm_data_d;
  logic       wm_rd_wrn_q, wm_rd_wrn_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;

  logic lfsr_fb;
  logic last_col;
  logic last_row;

  // Only the two LSBs of a pixel carry the watermark symbol.
  logic unused_pix_hi;
  assign unused_pix_hi = ^im_data_in_i[7:2];

  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign last_col = (c_q == LastIdx);
  assign last_row = (r_q == LastIdx);

  // Next-state, scan counters, keystream and registered RAM-side outputs.
  always_comb begin
    state_d     = state_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    r_d         = r_q;
    c_d         = c_q;
    lfsr_d      = lfsr_q;
    row_im_d    = row_im_q;
    col_im_d    = col_im_q;
    row_wm_d    = row_wm_q;
    col_wm_d    = col_wm_q;
    wm_data_d   = wm_data_q;
    wm_rd_wrn_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          a1_d     = a1_i;
          a2_d     = a2_i;
          r_d      = 8'd0;
          c_d      = 8'd0;
          // An all-zero seed would lock the LFSR at zero.
          lfsr_d   = (key_i == 8'h00) ? 8'h01 : key_i;
          row_im_d = a1_i;
          col_im_d = a2_i;
          state_d  = StRd;
        end
      end
      StRd: begin
        state_d = StWait;
      end
      StWait: begin
        // Pixel is sampled at the end of WAIT; the write is presented during WR.
        wm_rd_wrn_d = 1'b0;
        row_wm_d    = r_q;
        col_wm_d    = c_q;
        wm_data_d   = im_data_in_i[1:0] ^ lfsr_q[1:0];
        state_d     = StWr;
      end
      StWr: begin
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        if (last_col) begin
          c_d = 8'd0;
          r_d = r_q + 8'd1;
        end else begin
          c_d = c_q + 8'd1;
        end
        if (last_row && last_col) begin
          state_d = StIdle;
        end else begin
          // Window origin plus offset wraps modulo 256.
          row_im_d = a1_q + r_d;
          col_im_d = a2_q + c_d;
          state_d  = StRd;
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      a1_q        <= 8'd0;
      a2_q        <= 8'd0;
      r_q         <= 8'd0;
      c_q         <= 8'd0;
      lfsr_q      <= 8'd0;
      row_im_q    <= 8'd0;
      col_im_q    <= 8'd0;
      row_wm_q    <= 8'd0;
      col_wm_q    <= 8'd0;
      wm_data_q   <= 2'd0;
      wm_rd_wrn_q <= 1'b1;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      r_q         <= r_d;
      c_q         <= c_d;
      lfsr_q      <= lfsr_d;
      row_im_q    <= row_im_d;
      col_im_q    <= col_im_d;
      row_wm_q    <= row_wm_d;
      col_wm_q    <= col_wm_d;
      wm_data_q   <= wm_data_d;
      wm_rd_wrn_q <= wm_rd_wrn_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign row_im_addr_o = row_im_q;
  assign col_im_addr_o = col_im_q;
  assign im_rd_wrn_o   = 1'b1;
  assign row_wm_addr_o = row_wm_q;
  assign col_wm_addr_o = col_wm_q;
  assign wm_data_o     = wm_data_q;
  assign wm_rd_wrn_o   = wm_rd_wrn_q;
  assign ready_o       = ready_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_wm_extract.sv
// Directed bench for wm_extract: a 2x2 instance for keystream, wrap, busy and reset
// scenarios, and a 4x4 instance for a full descramble round trip.
module tb_wm_extract;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start2, start4;
  logic [7:0] key, a1, a2;
  logic [7:0] im_data2, im_data4;

  logic [7:0] row_im2, col_im2, row_wm2, col_wm2;
  logic [7:0] row_im4, col_im4, row_wm4, col_wm4;
  logic [1:0] wm_data2, wm_data4;
  logic       im_rdwr2, wm_rdwr2, ready2, busy2;
  logic       im_rdwr4, wm_rdwr4, ready4, busy4;

  int checks = 0;
  int errors = 0;

  wm_extract #(.WM_DIM(2)) u_dut2 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start2),
    .key_i        (key),
    .a1_i         (a1),
    .a2_i         (a2),
    .im_data_in_i (im_data2),
    .row_im_addr_o(row_im2),
    .col_im_addr_o(col_im2),
    .im_rd_wrn_o  (im_rdwr2),
    .row_wm_addr_o(row_wm2),
    .col_wm_addr_o(col_wm2),
    .wm_data_o    (wm_data2),
    .wm_rd_wrn_o  (wm_rdwr2),
    .ready_o      (ready2),
    .busy_o       (busy2)
  );

  wm_extract #(.WM_DIM(4)) u_dut4 (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start4),
    .key_i        (key),
    .a1_i         (a1),
    .a2_i         (a2),
    .im_data_in_i (im_data4),
    .row_im_addr_o(row_im4),
    .col_im_addr_o(col_im4),
    .im_rd_wrn_o  (im_rdwr4),
    .row_wm_addr_o(row_wm4),
    .col_wm_addr_o(col_wm4),
    .wm_data_o    (wm_data4),
    .wm_rd_wrn_o  (wm_rdwr4),
    .ready_o      (ready4),
    .busy_o       (busy4)
  );

  // Image RAM model: synchronous read, data valid the cycle after the address.
  logic [7:0] img [0:65535];
  always @(posedge clk) begin
    im_data2 <= img[{row_im2, col_im2}];
    im_data4 <= img[{row_im4, col_im4}];
  end

  // Write monitor: each WM write is logged with the image address seen two cycles earlier.
  typedef struct packed {
    logic [7:0] wr;
    logic [7:0] wc;
    logic [1:0] d;
    logic [7:0] ir;
    logic [7:0] ic;
  } wr_t;

  wr_t wq2[$];
  wr_t wq4[$];
  logic [15:0] h1_2 = '0, h2_2 = '0, h1_4 = '0, h2_4 = '0;

  always @(negedge clk) begin
    if (wm_rdwr2 === 1'b0) wq2.push_back({row_wm2, col_wm2, wm_data2, h2_2});
    if (wm_rdwr4 === 1'b0) wq4.push_back({row_wm4, col_wm4, wm_data4, h2_4});
    h2_2 = h1_2;
    h1_2 = {row_im2, col_im2};
    h2_4 = h1_4;
    h1_4 = {row_im4, col_im4};
  end

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  task automatic kick(input bit sel4, input logic [7:0] k, input logic [7:0] x,
                      input logic [7:0] y);
    @(negedge clk);
    key = k;
    a1  = x;
    a2  = y;
    if (sel4) start4 = 1'b1;
    else start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic count_busy(input bit sel4, output int n);
    n = 0;
    while (((sel4 ? busy4 : busy2) === 1'b1) && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start2 = 1'b1;
    start4 = 1'b1;
    key    = 8'h5A;
    a1     = 8'h33;
    a2     = 8'h44;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready2, busy2, wm_rdwr2, im_rdwr2} !== 4'b1011) begin
      errors++;
      $display("FAIL reset_ctrl2: got %b expected 1011", {ready2, busy2, wm_rdwr2, im_rdwr2});
    end
    checks++;
    if ({row_im2, col_im2, row_wm2, col_wm2, wm_data2} !== 34'd0) begin
      errors++;
      $display("FAIL reset_addr2: got %h expected 0",
               {row_im2, col_im2, row_wm2, col_wm2, wm_data2});
    end
    checks++;
    if ({ready4, busy4, wm_rdwr4, im_rdwr4} !== 4'b1011) begin
      errors++;
      $display("FAIL reset_ctrl4: got %b expected 1011", {ready4, busy4, wm_rdwr4, im_rdwr4});
    end
    checks++;
    if ({row_im4, col_im4, row_wm4, col_wm4, wm_data4} !== 34'd0) begin
      errors++;
      $display("FAIL reset_addr4: got %h expected 0",
               {row_im4, col_im4, row_wm4, col_wm4, wm_data4});
    end
    rst    = 1'b0;
    start2 = 1'b0;
    start4 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ready2, busy2, ready4, busy4} !== 4'b1010 || wq2.size() != 0 || wq4.size() != 0) begin
      errors++;
      $display("FAIL reset_no_start: got ready/busy %b writes %0d/%0d expected 1010 0/0",
               {ready2, busy2, ready4, busy4}, wq2.size(), wq4.size());
    end
  endtask

  task automatic test_basic_keystream();
    logic [1:0] exp_d [4];
    int n;
    wr_t e;
    exp_d = '{2'd1, 2'd2, 2'd0, 2'd0};
    wq2.delete();
    kick(1'b0, 8'h00, 8'h10, 8'h10);
    count_busy(1'b0, n);
    repeat (2) @(negedge clk);
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL basic_busy_len: got %0d expected 12", n);
    end
    checks++;
    if (wq2.size() != 4) begin
      errors++;
      $display("FAIL basic_write_count: got %0d expected 4", wq2.size());
    end
    for (int i = 0; i < 4 && i < wq2.size(); i++) begin
      e = wq2[i];
      checks++;
      if (e.d !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_data[%0d]: got %0d expected %0d", i, e.d, exp_d[i]);
      end
      checks++;
      if ({e.wr, e.wc} !== {8'(i >> 1), 8'(i & 1)}) begin
        errors++;
        $display("FAIL basic_wm_addr[%0d]: got %h expected %h", i, {e.wr, e.wc},
                 {8'(i >> 1), 8'(i & 1)});
      end
      checks++;
      if ({e.ir, e.ic} !== {8'h10 + 8'(i >> 1), 8'h10 + 8'(i & 1)}) begin
        errors++;
        $display("FAIL basic_im_addr[%0d]: got %h expected %h", i, {e.ir, e.ic},
                 {8'h10 + 8'(i >> 1), 8'h10 + 8'(i & 1)});
      end
    end
  endtask

  task automatic test_address_wrap();
    logic [15:0] exp_im [4];
    int n;
    wr_t e;
    exp_im = '{16'hFFFF, 16'hFF00, 16'h00FF, 16'h0000};
    wq2.delete();
    kick(1'b0, 8'h77, 8'hFF, 8'hFF);
    count_busy(1'b0, n);
    repeat (2) @(negedge clk);
    checks++;
    if (wq2.size() != 4 || n != 12) begin
      errors++;
      $display("FAIL wrap_counts: got writes %0d busy %0d expected 4 12", wq2.size(), n);
    end
    for (int i = 0; i < 4 && i < wq2.size(); i++) begin
      e = wq2[i];
      checks++;
      if ({e.ir, e.ic} !== exp_im[i]) begin
        errors++;
        $display("FAIL wrap_im_addr[%0d]: got %h expected %h", i, {e.ir, e.ic}, exp_im[i]);
      end
      checks++;
      if ({e.wr, e.wc} !== {8'(i >> 1), 8'(i & 1)}) begin
        errors++;
        $display("FAIL wrap_wm_addr[%0d]: got %h expected %h", i, {e.wr, e.wc},
                 {8'(i >> 1), 8'(i & 1)});
      end
    end
  endtask

  task automatic test_round_trip();
    logic [1:0] pat [16];
    logic [7:0] s;
    logic [3:0] kk;
    logic [7:0] rr, cc;
    int n;
    wr_t e;
    s = 8'hA5;
    for (int k = 0; k < 16; k++) begin
      kk     = 4'(k);
      pat[k] = kk[1:0] ^ kk[3:2] ^ {kk[0], kk[3]};
      rr     = 8'h20 + 8'(k / 4);
      cc     = 8'h30 + 8'(k % 4);
      img[{rr, cc}] = {6'b101101, pat[k] ^ s[1:0]};
      s = lfsr_step(s);
    end
    wq4.delete();
    kick(1'b1, 8'hA5, 8'h20, 8'h30);
    count_busy(1'b1, n);
    repeat (2) @(negedge clk);
    checks++;
    if (n != 48) begin
      errors++;
      $display("FAIL rt_busy_len: got %0d expected 48", n);
    end
    checks++;
    if (wq4.size() != 16) begin
      errors++;
      $display("FAIL rt_write_count: got %0d expected 16", wq4.size());
    end
    for (int k = 0; k < 16 && k < wq4.size(); k++) begin
      e = wq4[k];
      checks++;
      if (e.d !== pat[k]) begin
        errors++;
        $display("FAIL rt_data[%0d]: got %0d expected %0d", k, e.d, pat[k]);
      end
      checks++;
      if ({e.wr, e.wc, e.ir, e.ic} !==
          {8'(k / 4), 8'(k % 4), 8'h20 + 8'(k / 4), 8'h30 + 8'(k % 4)}) begin
        errors++;
        $display("FAIL rt_addr[%0d]: got %h expected %h", k, {e.wr, e.wc, e.ir, e.ic},
                 {8'(k / 4), 8'(k % 4), 8'h20 + 8'(k / 4), 8'h30 + 8'(k % 4)});
      end
    end
  endtask

  task automatic test_start_while_busy();
    logic [1:0] exp_d [4];
    int n;
    exp_d = '{2'd1, 2'd2, 2'd0, 2'd0};
    wq2.delete();
    kick(1'b0, 8'h00, 8'h10, 8'h10);
    n = 0;
    while (busy2 === 1'b1 && n < 1000) begin
      if (n == 4) begin
        start2 = 1'b1;
        key    = 8'h3C;
        a1     = 8'h55;
        a2     = 8'h66;
      end else if (n == 5) begin
        start2 = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    start2 = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (n != 12) begin
      errors++;
      $display("FAIL busy_run_len: got %0d expected 12", n);
    end
    checks++;
    if ({ready2, busy2} !== 2'b10 || wq2.size() != 4) begin
      errors++;
      $display("FAIL busy_no_restart: got ready/busy %b writes %0d expected 10 4",
               {ready2, busy2}, wq2.size());
    end
    for (int i = 0; i < 4 && i < wq2.size(); i++) begin
      checks++;
      if (wq2[i].d !== exp_d[i] || {wq2[i].ir, wq2[i].ic} !==
          {8'h10 + 8'(i >> 1), 8'h10 + 8'(i & 1)}) begin
        errors++;
        $display("FAIL busy_write[%0d]: got d=%0d im=%h expected d=%0d im=%h", i, wq2[i].d,
                 {wq2[i].ir, wq2[i].ic}, exp_d[i], {8'h10 + 8'(i >> 1), 8'h10 + 8'(i & 1)});
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] exp_d [4];
    int n;
    exp_d = '{2'd1, 2'd2, 2'd0, 2'd0};
    wq2.delete();
    kick(1'b0, 8'h00, 8'h10, 8'h10);
    // Now in cycle 1; cycle 8 is the WAIT of the third pixel.
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({ready2, busy2, wm_rdwr2} !== 3'b101 || wq2.size() != 2) begin
      errors++;
      $display("FAIL midrst_state: got rdy/bsy/we %b writes %0d expected 101 2",
               {ready2, busy2, wm_rdwr2}, wq2.size());
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wq2.size() != 2 || ready2 !== 1'b1) begin
      errors++;
      $display("FAIL midrst_quiet: got writes %0d ready %b expected 2 1", wq2.size(), ready2);
    end
    wq2.delete();
    kick(1'b0, 8'h00, 8'h10, 8'h10);
    count_busy(1'b0, n);
    repeat (2) @(negedge clk);
    checks++;
    if (n != 12 || wq2.size() != 4) begin
      errors++;
      $display("FAIL midrst_rerun: got busy %0d writes %0d expected 12 4", n, wq2.size());
    end
    for (int i = 0; i < 4 && i < wq2.size(); i++) begin
      checks++;
      if (wq2[i].d !== exp_d[i] || {wq2[i].wr, wq2[i].wc} !== {8'(i >> 1), 8'(i & 1)}) begin
        errors++;
        $display("FAIL midrst_write[%0d]: got d=%0d wm=%h expected d=%0d wm=%h", i, wq2[i].d,
                 {wq2[i].wr, wq2[i].wc}, exp_d[i], {8'(i >> 1), 8'(i & 1)});
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 65536; i++) img[i] = 8'h00;
    test_reset();
    test_basic_keystream();
    test_address_wrap();
    test_round_trip();
    test_start_while_busy();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wm_extract.md
# wm_extract

Watermark extraction engine, the read-side counterpart of the watermark embedder top level. After a `start` pulse it walks a WM_DIM×WM_DIM window of the watermarked image memory anchored at (a1, a2). For each pixel it recovers the 2-bit watermark symbol from the pixel's two LSBs, descrambles it with the same key-seeded LFSR keystream the embedder uses, and writes the symbol into the watermark memory at the window-relative coordinate. It sits between the image RAM (read-only from this block) and the watermark RAM (write-only from this block).

## Interface
Parameters:
- WM_DIM, 64, watermark side length in pixels; legal range 1..256.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only while Ready=1.
- key  in  8  scrambling key; latched on accepted start.
- a1  in  8  image row origin of the window; latched on accepted start.
- a2  in  8  image column origin of the window; latched on accepted start.
- IM_data_in  in  8  image RAM read data; valid one cycle after the address is presented.
- Row_IM_addr  out  8  image RAM row address.
- Col_IM_addr  out  8  image RAM column address.
- IM_RD_WRn  out  1  image RAM direction; held at 1 (read) at all times.
- Row_WM_addr  out  8  watermark RAM row address.
- Col_WM_addr  out  8  watermark RAM column address.
- WM_data  out  2  extracted symbol to the watermark RAM.
- WM_RD_WRn  out  1  0 = write WM_data at this clock edge; 1 = idle/read.
- Ready  out  1  1 = idle and able to accept start.
- Busy  out  1  1 = extraction in progress; always equals ~Ready.

## Operation
- All outputs are registered. Reset values: Ready=1, Busy=0, IM_RD_WRn=1, WM_RD_WRn=1, all address outputs 0, WM_data=0.
- FSM states: IDLE, RD, WAIT, WR.
- IDLE: Ready=1. On start=1, latch key, a1 and a2. Clear r and c to 0 and seed the LFSR. Go to RD.
- RD: drive Row_IM_addr=a1+r and Col_IM_addr=a2+c. Both sums are 8-bit and wrap modulo 256. Go to WAIT.
- WAIT: capture IM_data_in into the pixel register at the end of the cycle. Go to WR.
- WR:
  - Drive WM_RD_WRn=0, Row_WM_addr=r, Col_WM_addr=c, WM_data = pix[1:0] XOR s[1:0], where s is the current LFSR state.
  - Advance the LFSR.
  - Increment c. At WM_DIM-1, set c=0 and increment r.
  - If (r,c) was (WM_DIM-1, WM_DIM-1), go to IDLE. Otherwise go to RD.
- In every state other than WR, WM_RD_WRn=1.
- LFSR:
  - 8-bit Fibonacci, shift left.
  - New LSB = s[7]^s[5]^s[4]^s[3].
  - Seed = key. If key=0x00, seed = 0x01 (avoids lockup).
  - Advances exactly once per pixel, in WR.
- Scan order is raster: row-major, column fastest.
- start while Busy=1 is ignored, and so are changes to key, a1 and a2 during a run.
- rst during any state forces every register to its reset value on the next edge. Any WR in progress in the same cycle as rst is still presented that cycle, but no further writes occur.

## Timing
- 3 cycles per pixel; no pipelining.
- Latency: start is accepted at edge E0. The first RD occurs in cycle 1 and the last WR in cycle 3·WM_DIM². Ready=1 in the cycle after that (WM_DIM=64 gives 12288 cycles busy).
- Image read contract: address presented during RD, data sampled at the end of WAIT.
- WM write contract: one write strobe per pixel, WM_RD_WRn=0 for exactly one cycle. Address and data are stable for the whole cycle.
- Back-to-back runs: start may be asserted in the first cycle Ready=1. It is accepted at that edge.

## Test plan
- Reset values: hold rst for 2 cycles with start=1 -> Ready=1, Busy=0, WM_RD_WRn=1, IM_RD_WRn=1, no state change.
- Basic keystream (WM_DIM=2): key=0x00, a1=a2=0x10, all pixels 0x00 -> writes (0,0)=1, (0,1)=2, (1,0)=0, (1,1)=0. Image reads go to (0x10,0x10), (0x10,0x11), (0x11,0x10), (0x11,0x11). Busy lasts 12 cycles.
- Address wrap (WM_DIM=2): a1=a2=0xFF -> image reads in order (FF,FF), (FF,00), (00,FF), (00,00). WM addresses are (0,0), (0,1), (1,0), (1,1).
- Round trip (WM_DIM=4): key=0xA5, image LSBs preloaded with pattern P XOR the model keystream -> all 16 WM writes equal P. Exactly 16 write strobes.
- Start and input changes while busy: pulse start and change key to 0x3C in cycle 5 of a run -> the run completes unchanged with the original keystream. No restart occurs.
- Reset mid-run: assert rst during the WAIT of pixel 2 -> next cycle Ready=1 and WM_RD_WRn=1, with no further writes. A new start then begins again at (0,0) with a fresh seed.
